// File: rtl/posi_mode_decoder_pkg.sv
// Shared constants, types and helpers for the intra luma mode decoder.
package posi_mode_decoder_pkg;

    localparam int unsigned MODE_W    = 6;
    localparam int unsigned LIST_W    = 3 * MODE_W;
    localparam int unsigned COORD_W   = 4;
    localparam int unsigned NUM_UNITS = 16;

    localparam logic [MODE_W-1:0] INVALID_MODE = 6'h3f;
    localparam logic [MODE_W-1:0] MODE_PLANAR  = 6'd0;
    localparam logic [MODE_W-1:0] MODE_DC      = 6'd1;
    localparam logic [MODE_W-1:0] MODE_VER     = 6'd26;

    typedef enum logic [1:0] {
        SIZE_04 = 2'd0,
        SIZE_08 = 2'd1,
        SIZE_16 = 2'd2,
        SIZE_32 = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NBR  = 2'd1,
        ST_MPM  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Latched PU syntax with the z-order position already split into x/y.
    typedef struct packed {
        size_e              size;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               flag;
        logic [1:0]         idx;
        logic [4:0]         rem;
    } pu_syntax_t;

    function automatic logic [MODE_W-1:0] resolve_dc(input logic [MODE_W-1:0] m);
        return (m == INVALID_MODE) ? MODE_DC : m;
    endfunction

endpackage

// File: rtl/posi_mode_decoder_mpm.sv
// Combinational 3-entry MPM derivation and mode reconstruction from parsed syntax.
module posi_mpm_derive
    import posi_mode_decoder_pkg::*;
(
    input  logic [MODE_W-1:0] mode_a_i,
    input  logic [MODE_W-1:0] mode_b_i,
    input  logic              mpm_flag_i,
    input  logic [1:0]        mpm_idx_i,
    input  logic [4:0]        rem_mode_i,
    output logic [LIST_W-1:0] mpm_list_c,
    output logic [MODE_W-1:0] mode_c
);

    logic [MODE_W-1:0] cand0, cand1, cand2;
    logic [MODE_W-1:0] sum_p, sum_m;
    logic [MODE_W-1:0] s0, s1, s2, tmp;
    logic [MODE_W-1:0] rem_adj;

    always_comb begin
        cand0 = mode_a_i;
        cand1 = mode_b_i;
        cand2 = MODE_VER;
        sum_p = mode_a_i + 6'd29;
        sum_m = mode_a_i - 6'd1;
        if (mode_a_i == mode_b_i) begin
            if (mode_a_i < 6'd2) begin
                cand0 = MODE_PLANAR;
                cand1 = MODE_DC;
                cand2 = MODE_VER;
            end else begin
                cand1 = 6'd2 + {1'b0, sum_p[4:0]};
                cand2 = 6'd2 + {1'b0, sum_m[4:0]};
            end
        end else if (mode_a_i != MODE_PLANAR && mode_b_i != MODE_PLANAR) begin
            cand2 = MODE_PLANAR;
        end else if (mode_a_i != MODE_DC && mode_b_i != MODE_DC) begin
            cand2 = MODE_DC;
        end
    end

    // Ascending sort of the candidates, then skip over each one in turn.
    always_comb begin
        s0  = cand0;
        s1  = cand1;
        s2  = cand2;
        tmp = '0;
        if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
        if (s1 > s2) begin tmp = s1; s1 = s2; s2 = tmp; end
        if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
        rem_adj = {1'b0, rem_mode_i};
        if (rem_adj >= s0) rem_adj = rem_adj + 6'd1;
        if (rem_adj >= s1) rem_adj = rem_adj + 6'd1;
        if (rem_adj >= s2) rem_adj = rem_adj + 6'd1;
    end

    always_comb begin
        mpm_list_c = {cand2, cand1, cand0};
        mode_c     = rem_adj;
        if (mpm_flag_i) begin
            case (mpm_idx_i)
                2'd0:    mode_c = cand0;
                2'd1:    mode_c = cand1;
                default: mode_c = cand2;
            endcase
        end
    end

endmodule

// File: rtl/posi_mode_decoder.sv
// Intra luma mode decoder: handshake FSM, 4x4-granular top/left line buffers, MPM stage.
module posi_mode_decoder
    import posi_mode_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ctu_start_i,
    input  logic              lft_ctu_avail_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        size_i,
    input  logic [7:0]        position_i,
    input  logic              mpm_flag_i,
    input  logic [1:0]        mpm_idx_i,
    input  logic [4:0]        rem_mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [MODE_W-1:0] mode_o,
    output logic [LIST_W-1:0] mpm_list_o
);

    state_e            state_q, state_d;
    pu_syntax_t        pu_q, pu_d;
    logic [MODE_W-1:0] mode_a_q, mode_a_d, mode_b_q, mode_b_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [LIST_W-1:0] mpm_list_q, mpm_list_d;
    logic [MODE_W-1:0] top_buf_q [NUM_UNITS];
    logic [MODE_W-1:0] top_buf_d [NUM_UNITS];
    logic [MODE_W-1:0] lft_buf_q [NUM_UNITS];
    logic [MODE_W-1:0] lft_buf_d [NUM_UNITS];

    logic [MODE_W-1:0] derive_mode_c;
    logic [LIST_W-1:0] derive_list_c;
    logic [4:0]        span_c;

    posi_mpm_derive u_mpm (
        .mode_a_i   (mode_a_q),
        .mode_b_i   (mode_b_q),
        .mpm_flag_i (pu_q.flag),
        .mpm_idx_i  (pu_q.idx),
        .rem_mode_i (pu_q.rem),
        .mpm_list_c (derive_list_c),
        .mode_c     (derive_mode_c)
    );

    assign span_c = 5'd1 << pu_q.size;

    always_comb begin
        state_d     = state_q;
        pu_d        = pu_q;
        mode_a_d    = mode_a_q;
        mode_b_d    = mode_b_q;
        out_valid_d = out_valid_q;
        mode_d      = mode_q;
        mpm_list_d  = mpm_list_q;
        top_buf_d   = top_buf_q;
        lft_buf_d   = lft_buf_q;

        case (state_q)
            ST_IDLE: begin
                // CTU clear lands on the same edge as an accept, ahead of the NBR read.
                if (ctu_start_i) begin
                    for (int i = 0; i < NUM_UNITS; i++) begin
                        top_buf_d[i] = INVALID_MODE;
                        if (!lft_ctu_avail_i) lft_buf_d[i] = INVALID_MODE;
                    end
                end
                if (in_valid_i) begin
                    pu_d.size = size_e'(size_i);
                    pu_d.x    = {position_i[6], position_i[4], position_i[2], position_i[0]};
                    pu_d.y    = {position_i[7], position_i[5], position_i[3], position_i[1]};
                    pu_d.flag = mpm_flag_i;
                    pu_d.idx  = mpm_idx_i;
                    pu_d.rem  = rem_mode_i;
                    state_d   = ST_NBR;
                end
            end
            ST_NBR: begin
                mode_a_d = resolve_dc(lft_buf_q[pu_q.y]);
                mode_b_d = (pu_q.y == '0) ? MODE_DC : resolve_dc(top_buf_q[pu_q.x]);
                state_d  = ST_MPM;
            end
            ST_MPM: begin
                mode_d      = derive_mode_c;
                mpm_list_d  = derive_list_c;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    for (int i = 0; i < NUM_UNITS; i++) begin
                        if (5'(i) >= {1'b0, pu_q.x} && 5'(i) < {1'b0, pu_q.x} + span_c)
                            top_buf_d[i] = mode_q;
                        if (5'(i) >= {1'b0, pu_q.y} && 5'(i) < {1'b0, pu_q.y} + span_c)
                            lft_buf_d[i] = mode_q;
                    end
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pu_q        <= '0;
            mode_a_q    <= MODE_DC;
            mode_b_q    <= MODE_DC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mode_q      <= '0;
            mpm_list_q  <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                top_buf_q[i] <= INVALID_MODE;
                lft_buf_q[i] <= INVALID_MODE;
            end
        end else begin
            state_q     <= state_d;
            pu_q        <= pu_d;
            mode_a_q    <= mode_a_d;
            mode_b_q    <= mode_b_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
            mpm_list_q  <= mpm_list_d;
            top_buf_q   <= top_buf_d;
            lft_buf_q   <= lft_buf_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign mode_o      = mode_q;
    assign mpm_list_o  = mpm_list_q;

endmodule

// File: tb/tb_posi_mode_decoder.sv
// Directed self-checking bench for posi_mode_decoder with hand-computed modes and MPM lists.
module tb_posi_mode_decoder;
    import posi_mode_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctu_start_i = 1'b0;
    logic        lft_ctu_avail_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [1:0]  size_i = 2'd0;
    logic [7:0]  position_i = 8'd0;
    logic        mpm_flag_i = 1'b0;
    logic [1:0]  mpm_idx_i = 2'd0;
    logic [4:0]  rem_mode_i = 5'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [5:0]  mode_o;
    logic [17:0] mpm_list_o;

    int checks = 0;
    int errors = 0;

    posi_mode_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .ctu_start_i     (ctu_start_i),
        .lft_ctu_avail_i (lft_ctu_avail_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .size_i          (size_i),
        .position_i      (position_i),
        .mpm_flag_i      (mpm_flag_i),
        .mpm_idx_i       (mpm_idx_i),
        .rem_mode_i      (rem_mode_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .mode_o          (mode_o),
        .mpm_list_o      (mpm_list_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] lst(input int c0, input int c1, input int c2);
        return {6'(c2), 6'(c1), 6'(c0)};
    endfunction

    // Issue one PU with out_ready_i high; returns cycles to out_valid_o and captured outputs.
    task automatic run_pu(input logic ctu, input logic avail, input logic [7:0] pos,
                          input logic [1:0] size, input logic flag, input logic [1:0] idx,
                          input logic [4:0] rem, output int lat, output logic [5:0] mode,
                          output logic [17:0] list);
        ctu_start_i = ctu; lft_ctu_avail_i = avail; in_valid_i = 1'b1;
        position_i = pos; size_i = size; mpm_flag_i = flag; mpm_idx_i = idx; rem_mode_i = rem;
        step();
        in_valid_i = 1'b0; ctu_start_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            step();
            lat++;
        end
        mode = mode_o;
        list = mpm_list_o;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid_o); end
        checks++; if (mode_o !== 6'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode_o); end
        checks++; if (mpm_list_o !== 18'd0) begin errors++; $display("FAIL reset_list got %h exp 0", mpm_list_o); end
    endtask

    task automatic test_first_pu();
        int lat; logic [5:0] m; logic [17:0] l;
        run_pu(1'b1, 1'b0, 8'h00, SIZE_08, 1'b1, 2'd0, 5'd0, lat, m, l);
        checks++; if (lat !== 3) begin errors++; $display("FAIL first_latency got %0d exp 3", lat); end
        checks++; if (m !== 6'd0) begin errors++; $display("FAIL first_mode got %0d exp 0", m); end
        checks++; if (l !== lst(0, 1, 26)) begin errors++; $display("FAIL first_list got %h exp %h", l, lst(0, 1, 26)); end
    endtask

    task automatic test_rem_mode();
        int lat; logic [5:0] m; logic [17:0] l;
        run_pu(1'b0, 1'b0, 8'h00, SIZE_08, 1'b0, 2'd0, 5'd9, lat, m, l);
        checks++; if (m !== 6'd11) begin errors++; $display("FAIL rem9_mode got %0d exp 11", m); end
        checks++; if (l !== lst(0, 1, 26)) begin errors++; $display("FAIL rem9_list got %h exp %h", l, lst(0, 1, 26)); end
        run_pu(1'b0, 1'b0, 8'h04, SIZE_08, 1'b0, 2'd0, 5'd5, lat, m, l);
        checks++; if (m !== 6'd7) begin errors++; $display("FAIL rem5_mode got %0d exp 7", m); end
        checks++; if (l !== lst(11, 1, 0)) begin errors++; $display("FAIL rem5_list got %h exp %h", l, lst(11, 1, 0)); end
    endtask

    task automatic test_buffer_writes();
        int lat; logic [5:0] m; logic [17:0] l;
        run_pu(1'b0, 1'b0, 8'h04, SIZE_08, 1'b0, 2'd0, 5'd7, lat, m, l);
        checks++; if (m !== 6'd10) begin errors++; $display("FAIL wr04_mode got %0d exp 10", m); end
        checks++; if (l !== lst(7, 1, 0)) begin errors++; $display("FAIL wr04_list got %h exp %h", l, lst(7, 1, 0)); end
        run_pu(1'b0, 1'b0, 8'h08, SIZE_08, 1'b0, 2'd0, 5'd8, lat, m, l);
        checks++; if (m !== 6'd10) begin errors++; $display("FAIL wr08_mode got %0d exp 10", m); end
        checks++; if (l !== lst(1, 11, 0)) begin errors++; $display("FAIL wr08_list got %h exp %h", l, lst(1, 11, 0)); end
        run_pu(1'b0, 1'b0, 8'h0C, SIZE_08, 1'b1, 2'd1, 5'd0, lat, m, l);
        checks++; if (m !== 6'd9) begin errors++; $display("FAIL idx1_mode got %0d exp 9", m); end
        checks++; if (l !== lst(10, 9, 11)) begin errors++; $display("FAIL idx1_list got %h exp %h", l, lst(10, 9, 11)); end
        // Neighbours now 9/9, so idx 2 yields 10 and restores the 10/10 neighbourhood.
        run_pu(1'b0, 1'b0, 8'h0C, SIZE_08, 1'b1, 2'd2, 5'd0, lat, m, l);
        checks++; if (m !== 6'd10) begin errors++; $display("FAIL idx2a_mode got %0d exp 10", m); end
        checks++; if (l !== lst(9, 8, 10)) begin errors++; $display("FAIL idx2a_list got %h exp %h", l, lst(9, 8, 10)); end
        run_pu(1'b0, 1'b0, 8'h0C, SIZE_08, 1'b1, 2'd2, 5'd0, lat, m, l);
        checks++; if (m !== 6'd11) begin errors++; $display("FAIL idx2b_mode got %0d exp 11", m); end
        checks++; if (l !== lst(10, 9, 11)) begin errors++; $display("FAIL idx2b_list got %h exp %h", l, lst(10, 9, 11)); end
        run_pu(1'b0, 1'b0, 8'h0C, SIZE_08, 1'b1, 2'd3, 5'd0, lat, m, l);
        checks++; if (m !== 6'd12) begin errors++; $display("FAIL idx3_mode got %0d exp 12", m); end
        checks++; if (l !== lst(11, 10, 12)) begin errors++; $display("FAIL idx3_list got %h exp %h", l, lst(11, 10, 12)); end
    endtask

    task automatic test_backpressure();
        int lat; logic [5:0] m; logic [17:0] l;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; position_i = 8'h00; size_i = SIZE_08;
        mpm_flag_i = 1'b0; mpm_idx_i = 2'd0; rem_mode_i = 5'd3;
        step();
        in_valid_i = 1'b0;
        step(); step();
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_c3 got %0b exp 1", out_valid_o); end
        // Competing PU presented while stalled must not be taken.
        in_valid_i = 1'b1; position_i = 8'h04; mpm_flag_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (out_valid_o !== 1'b1 || mode_o !== 6'd5) begin errors++; $display("FAIL bp_hold cyc %0d got v=%0b m=%0d exp v=1 m=5", c, out_valid_o, mode_o); end
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %0b exp 0", c, in_ready_o); end
        end
        checks++; if (mpm_list_o !== lst(10, 1, 0)) begin errors++; $display("FAIL bp_list got %h exp %h", mpm_list_o, lst(10, 1, 0)); end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got v=%0b r=%0b exp v=0 r=1", out_valid_o, in_ready_o); end
        step(); step(); step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_accept got %0b exp 0", out_valid_o); end
        run_pu(1'b0, 1'b0, 8'h04, SIZE_08, 1'b0, 2'd0, 5'd0, lat, m, l);
        checks++; if (m !== 6'd2) begin errors++; $display("FAIL bp_after_mode got %0d exp 2", m); end
        checks++; if (l !== lst(5, 1, 0)) begin errors++; $display("FAIL bp_after_list got %h exp %h", l, lst(5, 1, 0)); end
    endtask

    task automatic test_ctu_boundary();
        int lat; logic [5:0] m; logic [17:0] l;
        run_pu(1'b1, 1'b0, 8'h00, SIZE_32, 1'b1, 2'd0, 5'd0, lat, m, l);
        checks++; if (m !== 6'd0) begin errors++; $display("FAIL ctu_seed_mode got %0d exp 0", m); end
        run_pu(1'b0, 1'b0, 8'h55, SIZE_04, 1'b0, 2'd0, 5'd18, lat, m, l);
        checks++; if (m !== 6'd20) begin errors++; $display("FAIL ctu_r0_mode got %0d exp 20", m); end
        checks++; if (l !== lst(0, 1, 26)) begin errors++; $display("FAIL ctu_r0_list got %h exp %h", l, lst(0, 1, 26)); end
        run_pu(1'b0, 1'b0, 8'h57, SIZE_04, 1'b1, 2'd1, 5'd0, lat, m, l);
        checks++; if (m !== 6'd20) begin errors++; $display("FAIL ctu_r1_mode got %0d exp 20", m); end
        checks++; if (l !== lst(0, 20, 1)) begin errors++; $display("FAIL ctu_r1_list got %h exp %h", l, lst(0, 20, 1)); end
        run_pu(1'b1, 1'b1, 8'h00, SIZE_08, 1'b1, 2'd0, 5'd0, lat, m, l);
        checks++; if (m !== 6'd20) begin errors++; $display("FAIL ctu_avail1_mode got %0d exp 20", m); end
        checks++; if (l !== lst(20, 1, 0)) begin errors++; $display("FAIL ctu_avail1_list got %h exp %h", l, lst(20, 1, 0)); end
        run_pu(1'b1, 1'b0, 8'h00, SIZE_08, 1'b1, 2'd0, 5'd0, lat, m, l);
        checks++; if (m !== 6'd0) begin errors++; $display("FAIL ctu_avail0_mode got %0d exp 0", m); end
        checks++; if (l !== lst(0, 1, 26)) begin errors++; $display("FAIL ctu_avail0_list got %h exp %h", l, lst(0, 1, 26)); end
    endtask

    task automatic test_reset_mid_pu();
        int lat; logic [5:0] m; logic [17:0] l;
        run_pu(1'b0, 1'b0, 8'h00, SIZE_08, 1'b0, 2'd0, 5'd5, lat, m, l);
        checks++; if (m !== 6'd7) begin errors++; $display("FAIL mid_seed_mode got %0d exp 7", m); end
        in_valid_i = 1'b1; position_i = 8'h00; size_i = SIZE_08;
        mpm_flag_i = 1'b1; mpm_idx_i = 2'd0;
        step();
        in_valid_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_state got v=%0b r=%0b exp v=0 r=1", out_valid_o, in_ready_o); end
        checks++; if (mode_o !== 6'd0 || mpm_list_o !== 18'd0) begin errors++; $display("FAIL mid_rst_outs got m=%0d l=%h exp 0", mode_o, mpm_list_o); end
        step(); step(); step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_dropped got %0b exp 0", out_valid_o); end
        run_pu(1'b1, 1'b1, 8'h00, SIZE_08, 1'b1, 2'd0, 5'd0, lat, m, l);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mid_after_latency got %0d exp 3", lat); end
        checks++; if (m !== 6'd0) begin errors++; $display("FAIL mid_after_mode got %0d exp 0", m); end
        checks++; if (l !== lst(0, 1, 26)) begin errors++; $display("FAIL mid_after_list got %h exp %h", l, lst(0, 1, 26)); end
    endtask

    initial begin
        test_reset();
        test_first_pu();
        test_rem_mode();
        test_buffer_writes();
        test_backpressure();
        test_ctu_boundary();
        test_reset_mid_pu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
